// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state enums plus opcode-class helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00,
        OP_SUB    = 5'h01,
        OP_XOR    = 5'h02,
        OP_OR     = 5'h03,
        OP_AND    = 5'h04,
        OP_SLL    = 5'h05,
        OP_SRL    = 5'h06,
        OP_SRA    = 5'h07,
        OP_SLT    = 5'h08,
        OP_SLTU   = 5'h09,
        OP_BEQ    = 5'h0A,
        OP_BNE    = 5'h0B,
        OP_BLT    = 5'h0C,
        OP_BGE    = 5'h0D,
        OP_BLTU   = 5'h0E,
        OP_BGEU   = 5'h0F,
        OP_MUL    = 5'h10,
        OP_MULH   = 5'h11,
        OP_MULHSU = 5'h12,
        OP_MULHU  = 5'h13,
        OP_DIV    = 5'h14,
        OP_DIVU   = 5'h15,
        OP_REM    = 5'h16,
        OP_REMU   = 5'h17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // RV-M block occupies 0x10-0x17.
    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    // Branch compares occupy 0x0A-0x0F.
    function automatic logic is_branch(input logic [4:0] op);
        return (op[4:3] == 2'b01) && (op[2:1] != 2'b00);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply (shift-add) / divide (restoring) engine with sign pre/post correction.
// Latency: exactly XLEN cycles after start; done pulses during the final iteration cycle.
// Backpressure: none; result holds in the registers until the next start.
// Ports: clk, rst (async active-high), flush (kills run), start (load operands),
//        op (low 3 bits of the M opcode), a/b operands, done pulse, result.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   hi_q;      // mul: product high half; div: partial remainder
    logic [XLEN-1:0]   lo_q;      // mul: multiplier / product low half; div: dividend -> quotient
    logic [XLEN-1:0]   mcand_q;   // mul: multiplicand magnitude; div: divisor magnitude
    logic              neg_q;     // negate product or quotient at the end
    logic              neg_rem_q; // remainder follows dividend sign

    // Operand signedness: MULH/MULHSU/DIV/REM treat a as signed; MULH/DIV/REM treat b as signed.
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        a_mag    = a_neg ? (~a + 1'b1) : a;
        b_mag    = b_neg ? (~b + 1'b1) : b;
    end

    // One iteration of each datapath.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_diff;
    logic            rem_ge;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh   = {hi_q, lo_q[XLEN-1]};
        // Remainder is always below the divisor, so the low XLEN bits of the
        // difference are exact whenever the shifted remainder reaches it.
        rem_diff = rem_sh[XLEN-1:0] - mcand_q;
        rem_ge   = rem_sh[XLEN] | (rem_sh[XLEN-1:0] >= mcand_q);
    end

    assign done = busy_q && (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (flush) begin
            busy_q <= 1'b0;
        end else if (start) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            op_q      <= op;
            hi_q      <= '0;
            lo_q      <= op[2] ? a_mag : b_mag;
            mcand_q   <= op[2] ? b_mag : a_mag;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
            if (op_q[2]) begin
                hi_q <= rem_ge ? rem_diff : rem_sh[XLEN-1:0];
                lo_q <= {lo_q[XLEN-2:0], rem_ge};
            end else begin
                hi_q <= mul_sum[XLEN:1];
                lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    always_comb begin
        prod_fix = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
        quot_fix = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem_fix  = neg_rem_q ? (~hi_q + 1'b1) : hi_q;
        if (op_q[2]) begin
            result = op_q[1] ? rem_fix : quot_fix;
        end else begin
            result = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32I/RV64I ALU + RV-M unit with valid/ready on both sides.
// Latency: 1 cycle for base/illegal/div-special ops, XLEN+1 for iterative M ops.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (forced low by flush).
// Ports: clk, rst (async active-high), flush, in_valid/in_ready, alu_op, rs1_data, rs2_data,
//        out_valid/out_ready, alu_out, zero (branch flag).
// Build option: FAST_MUL_EN makes MUL/MULH/MULHSU/MULHU single-cycle combinational.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            zero
);

    localparam int SHAMT_W = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic            eng_sel_q;   // result comes from the iterative engine

    logic            accept;
    logic            eng_start, eng_done;
    logic [XLEN-1:0] eng_result;

    assign in_ready  = (state_q == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);

    // Single-cycle evaluation of the incoming request.
    logic [SHAMT_W-1:0] shamt;
    logic               lt_s, lt_u, eq, b_zero, div_ovf;
    logic [XLEN-1:0]    quick_res;
    logic               cmp_flag;
    logic               quick;     // finishes in one cycle (IDLE -> DONE)

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fm_a, fm_b, fm_prod;
    always_comb begin
        fm_a    = {{XLEN{rs1_data[XLEN-1] & ((alu_op == OP_MULH) || (alu_op == OP_MULHSU))}}, rs1_data};
        fm_b    = {{XLEN{rs2_data[XLEN-1] & (alu_op == OP_MULH)}}, rs2_data};
        fm_prod = fm_a * fm_b;
    end
`endif

    always_comb begin
        shamt   = rs2_data[SHAMT_W-1:0];
        lt_s    = $signed(rs1_data) < $signed(rs2_data);
        lt_u    = rs1_data < rs2_data;
        eq      = rs1_data == rs2_data;
        b_zero  = rs2_data == '0;
        div_ovf = (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);

        quick_res = '0;
        cmp_flag  = 1'b0;
        quick     = !is_muldiv(alu_op);
        case (alu_op)
            OP_ADD:  quick_res = rs1_data + rs2_data;
            OP_SUB:  quick_res = rs1_data - rs2_data;
            OP_XOR:  quick_res = rs1_data ^ rs2_data;
            OP_OR:   quick_res = rs1_data | rs2_data;
            OP_AND:  quick_res = rs1_data & rs2_data;
            OP_SLL:  quick_res = rs1_data << shamt;
            OP_SRL:  quick_res = rs1_data >> shamt;
            OP_SRA:  quick_res = $signed(rs1_data) >>> shamt;
            OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, lt_u};
            OP_BEQ:  cmp_flag  = eq;
            OP_BNE:  cmp_flag  = !eq;
            OP_BLT:  cmp_flag  = lt_s;
            OP_BGE:  cmp_flag  = !lt_s;
            OP_BLTU: cmp_flag  = lt_u;
            OP_BGEU: cmp_flag  = !lt_u;
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
`ifdef FAST_MUL_EN
                quick     = 1'b1;
                quick_res = (alu_op == OP_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
`else
                quick     = 1'b0;
`endif
            end
            // alu_op[1] separates REM/REMU from DIV/DIVU.
            OP_DIV, OP_REM: begin
                if (b_zero) begin
                    quick     = 1'b1;
                    quick_res = alu_op[1] ? rs1_data : '1;
                end else if (div_ovf) begin
                    quick     = 1'b1;
                    quick_res = alu_op[1] ? '0 : rs1_data;
                end
            end
            OP_DIVU, OP_REMU: begin
                if (b_zero) begin
                    quick     = 1'b1;
                    quick_res = alu_op[1] ? rs1_data : '1;
                end
            end
            default: ;  // illegal opcodes produce 0 / zero=0
        endcase
    end

    assign eng_start = accept && !quick;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (eng_start),
        .op     (alu_op[2:0]),
        .a      (rs1_data),
        .b      (rs2_data),
        .done   (eng_done),
        .result (eng_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = quick ? DONE : BUSY;
            BUSY:    if (eng_done)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q     <= '0;
            zero_q    <= 1'b0;
            eng_sel_q <= 1'b0;
        end else if (accept) begin
            res_q     <= quick_res;
            zero_q    <= is_branch(alu_op) & cmp_flag;
            eng_sel_q <= !quick;
        end
    end

    // Outputs read as zero outside DONE so a flushed or reset op leaves nothing visible.
    assign alu_out = (state_q == DONE) ? (eng_sel_q ? eng_result : res_q) : '0;
    assign zero    = (state_q == DONE) && zero_q;

endmodule
